pql_train_ctrl: RTL and testbench

Training sequencer for the parallel Q-learning datapath. It takes a start command, clears the Q-tables, and gates the per-state Sn update enables for a programmed number of iterations per episode and a programmed number of episodes. It can stop early once the reported Q-value change has stayed below a threshold for several consecutive iterations. It sits between the host/testbench control registers and the PQL top level, and drives the top level's update enable and table clear.

---
 rtl/pql_pkg.sv | 16 +
 rtl/pql_conv_detect.sv | 46 ++++
 rtl/pql_train_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_pql_train_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pql_pkg.sv
// Shared types and constants for the PQL training sequencer.
// Early stop is built only when PQL_EARLY_STOP_EN is defined.
package pql_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    EP_END,
    DONE
  } pql_state_e;

  localparam int CLEAR_CYCLES = 2;
  localparam int PQL_DATA_W   = 24;

endpackage

// File: rtl/pql_conv_detect.sv
// Counts consecutive sub-threshold Q deltas, saturating at STABLE_N.
// Used by pql_train_ctrl only when PQL_EARLY_STOP_EN is defined.
module pql_conv_detect
  import pql_pkg::*;
#(
  parameter int DATA_W   = PQL_DATA_W,
  parameter int STABLE_N = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] q_delta,
  input  logic [DATA_W-1:0] thresh,
  output logic              hit
);

  localparam int CW = $clog2(STABLE_N + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Equality with the threshold breaks the streak.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (q_delta >= thresh) begin
        cnt_d = '0;
      end else if (cnt_q != CW'(STABLE_N)) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = (cnt_q == CW'(STABLE_N));

endmodule

// File: rtl/pql_train_ctrl.sv
// Training sequencer: clears Q-tables, gates update enables per episode.
// Define PQL_EARLY_STOP_EN to build the convergence early-stop logic.
module pql_train_ctrl
  import pql_pkg::*;
#(
  parameter int ITER_W   = 16,
  parameter int EP_W     = 12,
  parameter int DATA_W   = PQL_DATA_W,
  parameter int STABLE_N = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              abort,
  input  logic [ITER_W-1:0] iters_per_ep,
  input  logic [EP_W-1:0]   num_episodes,
  input  logic [DATA_W-1:0] eps_thresh,
  input  logic [DATA_W-1:0] q_delta,
  input  logic              q_delta_vld,
  output logic              dp_rst,
  output logic              dp_en,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic              aborted,
  output logic [EP_W-1:0]   ep_cnt,
  output logic [ITER_W-1:0] iter_cnt
);

  localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);

  pql_state_e        state_q, state_d;
  logic [CLR_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic [ITER_W-1:0] iters_q, iters_d;
  logic [EP_W-1:0]   neps_q, neps_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [EP_W-1:0]   ep_q, ep_d;
  logic              abt_q, abt_d;
  logic              dp_rst_q, dp_rst_d;
  logic              dp_en_q, dp_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              new_run;
  logic              conv_hit;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    iters_d   = iters_q;
    neps_d    = neps_q;
    iter_d    = iter_q;
    ep_d      = ep_q;
    abt_d     = abt_q;
    new_run   = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          new_run = 1'b1;
          ep_d    = '0;
          iter_d  = '0;
          abt_d   = 1'b0;
          if (iters_per_ep == '0 || num_episodes == '0) begin
            state_d = DONE;
          end else begin
            state_d   = CLEAR;
            clr_cnt_d = '0;
            iters_d   = iters_per_ep;
            neps_d    = num_episodes;
          end
        end
      end
      CLEAR: begin
        if (abort) begin
          state_d = DONE;
          abt_d   = 1'b1;
        end else if (clr_cnt_q == CLR_W'(CLEAR_CYCLES - 1)) begin
          state_d = RUN;
        end else begin
          clr_cnt_d = clr_cnt_q + CLR_W'(1);
        end
      end
      RUN: begin
        if (abort) begin
          state_d = DONE;
          abt_d   = 1'b1;
        end else if (iter_q == iters_q - ITER_W'(1)) begin
          state_d = EP_END;
        end else begin
          iter_d = iter_q + ITER_W'(1);
        end
      end
      EP_END: begin
        if (abort) begin
          state_d = DONE;
          abt_d   = 1'b1;
        end else if (ep_q == neps_q - EP_W'(1) || conv_hit) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
          ep_d    = ep_q + EP_W'(1);
          iter_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs decode the next state so they are registered alongside it.
    dp_rst_d = (state_d == CLEAR);
    dp_en_d  = (state_d == RUN);
    busy_d   = (state_d == CLEAR) || (state_d == RUN)
            || (state_d == EP_END);
    done_d   = (state_d == DONE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      clr_cnt_q <= '0;
      iters_q   <= '0;
      neps_q    <= '0;
      iter_q    <= '0;
      ep_q      <= '0;
      abt_q     <= 1'b0;
      dp_rst_q  <= 1'b0;
      dp_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      iters_q   <= iters_d;
      neps_q    <= neps_d;
      iter_q    <= iter_d;
      ep_q      <= ep_d;
      abt_q     <= abt_d;
      dp_rst_q  <= dp_rst_d;
      dp_en_q   <= dp_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef PQL_EARLY_STOP_EN
  logic              conv_q, conv_d;
  logic [DATA_W-1:0] thresh_q, thresh_d;

  always_comb begin
    conv_d   = conv_q;
    thresh_d = thresh_q;
    if (new_run) begin
      conv_d   = 1'b0;
      thresh_d = eps_thresh;
    end else if (state_q == EP_END && !abort && conv_hit) begin
      conv_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      conv_q   <= 1'b0;
      thresh_q <= '0;
    end else begin
      conv_q   <= conv_d;
      thresh_q <= thresh_d;
    end
  end

  pql_conv_detect #(
    .DATA_W   (DATA_W),
    .STABLE_N (STABLE_N)
  ) u_conv (
    .clk     (CLK),
    .rst     (RST),
    .clr     (state_q == CLEAR),
    .en      (dp_en_q & q_delta_vld),
    .q_delta (q_delta),
    .thresh  (thresh_q),
    .hit     (conv_hit)
  );

  assign converged = conv_q;
`else
  logic unused_in;

  assign conv_hit  = 1'b0;
  assign converged = 1'b0;
  assign unused_in = ^{eps_thresh, q_delta, q_delta_vld, new_run}
                   ^ (STABLE_N == 0);
`endif

  assign dp_rst   = dp_rst_q;
  assign dp_en    = dp_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign aborted  = abt_q;
  assign ep_cnt   = ep_q;
  assign iter_cnt = iter_q;

endmodule

// File: tb/tb_pql_train_ctrl.sv
// Self-checking bench for pql_train_ctrl: run-schedule model plus
// directed scenarios; follows PQL_EARLY_STOP_EN when it is defined.
module tb_pql_train_ctrl;

  localparam int ITER_W   = 16;
  localparam int EP_W     = 12;
  localparam int DATA_W   = 24;
  localparam int STABLE_N = 8;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ITER_W-1:0] iters_per_ep = '0;
  logic [EP_W-1:0]   num_episodes = '0;
  logic [DATA_W-1:0] eps_thresh = '0;
  logic [DATA_W-1:0] q_delta = '0;
  logic              q_delta_vld = 1'b0;
  logic              dp_rst, dp_en, busy, done, converged, aborted;
  logic [EP_W-1:0]   ep_cnt;
  logic [ITER_W-1:0] iter_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int qmode   = 0;

  pql_train_ctrl #(
    .ITER_W   (ITER_W),
    .EP_W     (EP_W),
    .DATA_W   (DATA_W),
    .STABLE_N (STABLE_N)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .start        (start),
    .abort        (abort),
    .iters_per_ep (iters_per_ep),
    .num_episodes (num_episodes),
    .eps_thresh   (eps_thresh),
    .q_delta      (q_delta),
    .q_delta_vld  (q_delta_vld),
    .dp_rst       (dp_rst),
    .dp_en        (dp_en),
    .busy         (busy),
    .done         (done),
    .converged    (converged),
    .aborted      (aborted),
    .ep_cnt       (ep_cnt),
    .iter_cnt     (iter_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Datapath delta stimulus
  always @(negedge CLK) begin
    case (qmode)
      1: begin
        q_delta_vld = 1'b1;
        q_delta = (ep_cnt != 0 || iter_cnt >= 2) ? 24'h80 : 24'h200;
      end
      2: begin
        q_delta_vld = 1'b1;
        q_delta = 24'h100;
      end
      default: begin
        q_delta_vld = 1'b0;
        q_delta = '0;
      end
    endcase
  end

  // Model: 0 idle, 1 running (CLEAR..EP_END), 2 done. While running,
  // m_t counts cycles since the start edge and the schedule is
  // 2 clear cycles followed by E blocks of I enables plus one bubble.
  int          m_mode = 0;
  int          m_t = 0;
  int          m_i = 0;
  int          m_e = 0;
  int          m_stab = 0;
  logic [23:0] m_thr = '0;
  bit          m_conv = 0;
  bit          m_abt = 0;
  bit          e_rst = 0, e_en = 0, e_busy = 0, e_done = 0, e_bub = 0;
  int          e_ep = 0;
  int          e_it = 0;

  task automatic model_step();
    bit last, hit;
    int r, p;
    if (RST) begin
      m_mode = 0; m_conv = 0; m_abt = 0; e_ep = 0; e_it = 0;
    end else if (m_mode == 1 && abort) begin
      m_mode = 2; m_abt = 1;
    end else if (m_mode != 1 && start) begin
      m_conv = 0; m_abt = 0; e_ep = 0; e_it = 0; m_stab = 0;
      m_thr = eps_thresh;
      if (iters_per_ep == 0 || num_episodes == 0) m_mode = 2;
      else begin
        m_mode = 1; m_t = 0;
        m_i = int'(iters_per_ep); m_e = int'(num_episodes);
      end
    end else if (m_mode == 1) begin
`ifdef PQL_EARLY_STOP_EN
      if (e_en && q_delta_vld) begin
        if (q_delta < m_thr) m_stab = (m_stab < STABLE_N) ? m_stab + 1 : STABLE_N;
        else m_stab = 0;
      end
      hit = (m_stab >= STABLE_N);
`else
      hit = 0;
`endif
      last = (e_ep == m_e - 1);
      if (e_bub && (last || hit)) begin
        m_mode = 2; m_conv = hit;
      end else m_t++;
    end
    e_rst = 0; e_en = 0; e_busy = 0; e_done = 0; e_bub = 0;
    if (m_mode == 1) begin
      e_busy = 1;
      if (m_t < 2) e_rst = 1;
      else begin
        r = m_t - 2;
        e_ep = r / (m_i + 1);
        p = r % (m_i + 1);
        e_bub = (p == m_i);
        e_en = !e_bub;
        e_it = e_bub ? m_i - 1 : p;
      end
    end else if (m_mode == 2) e_done = 1;
  endtask

  always begin
    @(posedge CLK);
    model_step();
    #1;
    chk("cyc_dp_rst", dp_rst, e_rst);
    chk("cyc_dp_en", dp_en, e_en);
    chk("cyc_busy", busy, e_busy);
    chk("cyc_done", done, e_done);
    chk("cyc_converged", converged, m_conv);
    chk("cyc_aborted", aborted, m_abt);
    chk("cyc_ep_cnt", ep_cnt, e_ep);
    chk("cyc_iter_cnt", iter_cnt, e_it);
  end

  int r_rst, r_en, r_done_t;
  int bub_q[$];

  task automatic do_start(input int i, input int e, input logic [23:0] th);
    @(negedge CLK);
    iters_per_ep = ITER_W'(i);
    num_episodes = EP_W'(e);
    eps_thresh = th;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  // Sample t=0 is the cycle right after the start edge.
  task automatic measure(input int budget);
    r_rst = 0; r_en = 0; r_done_t = -1;
    bub_q.delete();
    for (int t = 0; t < budget; t++) begin
      if (done) begin
        r_done_t = t;
        break;
      end
      if (dp_rst) r_rst++;
      if (dp_en) r_en++;
      if (busy && !dp_rst && !dp_en) bub_q.push_back(t);
      @(negedge CLK);
    end
    if (r_done_t < 0) chk("done_timeout", done, 1);
  endtask

  initial begin
    int found, en_seen;
    repeat (3) @(negedge CLK);
    chk("rst_outputs", {dp_rst, dp_en, busy, done, converged, aborted}, 0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    chk("idle_outputs", {dp_rst, dp_en, busy, done, converged, aborted}, 0);
    chk("idle_counters", {ep_cnt, iter_cnt}, 0);

    qmode = 0;
    do_start(4, 3, 24'h100);
    measure(200);
    chk("full_rst_cycles", r_rst, 2);
    chk("full_en_cycles", r_en, 12);
    chk("full_done_t", r_done_t, 17);
    chk("full_bubbles", bub_q.size(), 3);
    if (bub_q.size() == 3) begin
      chk("full_bub0", bub_q[0], 6);
      chk("full_bub1", bub_q[1], 11);
      chk("full_bub2", bub_q[2], 16);
    end
    chk("full_ep", ep_cnt, 2);
    chk("full_iter", iter_cnt, 3);
    chk("full_conv", converged, 0);

    qmode = 1;
    do_start(10, 100, 24'h100);
    measure(1500);
`ifdef PQL_EARLY_STOP_EN
    chk("es_conv", converged, 1);
    chk("es_ep", ep_cnt, 0);
    chk("es_en_cycles", r_en, 10);
    chk("es_done_t", r_done_t, 13);
`else
    chk("es_conv", converged, 0);
    chk("es_ep", ep_cnt, 99);
    chk("es_en_cycles", r_en, 1000);
`endif

    qmode = 2;
    do_start(4, 3, 24'h100);
    measure(200);
    chk("eq_conv", converged, 0);
    chk("eq_ep", ep_cnt, 2);
    chk("eq_en_cycles", r_en, 12);
    qmode = 0;

    do_start(5, 4, 24'h100);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (ep_cnt == 1 && iter_cnt == 2 && dp_en) begin
        found = 1;
        break;
      end
      @(negedge CLK);
    end
    chk("abort_reach", found, 1);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    chk("abort_done", done, 1);
    chk("abort_flag", aborted, 1);
    chk("abort_en_low", dp_en, 0);
    chk("abort_cnt", {ep_cnt, iter_cnt}, {12'd1, 16'd2});
    do_start(5, 4, 24'h100);
    chk("restart_abort_clr", aborted, 0);
    chk("restart_dp_rst", dp_rst, 1);
    measure(200);
    chk("restart_en_cycles", r_en, 20);
    chk("restart_done_t", r_done_t, 26);

    do_start(5, 0, 24'h100);
    chk("zero_ep_done", done, 1);
    chk("zero_ep_busy", busy, 0);
    en_seen = 0;
    for (int i = 0; i < 6; i++) begin
      en_seen += int'(dp_en);
      @(negedge CLK);
    end
    chk("zero_ep_no_en", en_seen, 0);
    do_start(0, 3, 24'h100);
    chk("zero_it_done", done, 1);
    chk("zero_it_no_en", dp_en, 0);

    do_start(8, 2, 24'h100);
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (dp_en) begin
        found = 1;
        break;
      end
      @(negedge CLK);
    end
    chk("mid_reach_run", found, 1);
    do_start(2, 1, 24'h100);
    chk("busy_start_ignored", {busy, dp_rst, dp_en}, 3'b101);
    RST = 1'b1;
    @(negedge CLK);
    chk("mid_rst_outputs", {dp_rst, dp_en, busy, done, converged, aborted}, 0);
    chk("mid_rst_counters", {ep_cnt, iter_cnt}, 0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    chk("mid_rst_idle", {dp_rst, dp_en, busy, done}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
